// File: rtl/seg7_pkg.sv
// Shared 7-segment pattern constants (active-low, bit order g..a) used by the
// encoder and decoder sides, plus the decode result type.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_7_ALT = 7'b1011000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_9_ALT = 7'b0011000;

  localparam logic [6:0] SEG_HEX_A = 7'b0001000;
  localparam logic [6:0] SEG_HEX_B = 7'b0000011;
  localparam logic [6:0] SEG_HEX_C = 7'b1000110;
  localparam logic [6:0] SEG_HEX_D = 7'b0100001;
  localparam logic [6:0] SEG_HEX_E = 7'b0000110;
  localparam logic [6:0] SEG_HEX_F = 7'b0001110;

  localparam logic [6:0] SEG_BLANK    = 7'h7F;
  localparam logic [3:0] CODE_INVALID = 4'hF;

  typedef struct packed {
    logic [3:0] code;
    logic       inv;
  } seg_decode_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational segment-pattern to digit-code decoder.
// Define SEG7_DEC_HEX_EN to also accept the A..F letter glyphs.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0]  segments,
  output seg_decode_t decode
);

  // NOTE: every output of an always_comb gets a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    decode.code = CODE_INVALID;
    decode.inv  = 1'b1;
    case (segments)
      SEG_0:            begin decode.code = 4'h0; decode.inv = 1'b0; end
      SEG_1:            begin decode.code = 4'h1; decode.inv = 1'b0; end
      SEG_2:            begin decode.code = 4'h2; decode.inv = 1'b0; end
      SEG_3:            begin decode.code = 4'h3; decode.inv = 1'b0; end
      SEG_4:            begin decode.code = 4'h4; decode.inv = 1'b0; end
      SEG_5:            begin decode.code = 4'h5; decode.inv = 1'b0; end
      SEG_6:            begin decode.code = 4'h6; decode.inv = 1'b0; end
      SEG_7, SEG_7_ALT: begin decode.code = 4'h7; decode.inv = 1'b0; end
      SEG_8:            begin decode.code = 4'h8; decode.inv = 1'b0; end
      SEG_9, SEG_9_ALT: begin decode.code = 4'h9; decode.inv = 1'b0; end
`ifdef SEG7_DEC_HEX_EN
      SEG_HEX_A:        begin decode.code = 4'hA; decode.inv = 1'b0; end
      SEG_HEX_B:        begin decode.code = 4'hB; decode.inv = 1'b0; end
      SEG_HEX_C:        begin decode.code = 4'hC; decode.inv = 1'b0; end
      SEG_HEX_D:        begin decode.code = 4'hD; decode.inv = 1'b0; end
      SEG_HEX_E:        begin decode.code = 4'hE; decode.inv = 1'b0; end
      SEG_HEX_F:        begin decode.code = 4'hF; decode.inv = 1'b0; end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Receive-side monitor for a multiplexed active-low 7-segment bus: debounces each
// digit's pattern and publishes per-digit codes and a frame-complete pulse.
// Letter glyphs decode only when SEG7_DEC_HEX_EN is defined (see seg7_pattern_decode).
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int STABLE_CNT = 3
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    sample_en,
  input  logic [6:0]              segments,
  input  logic [NUM_DIGITS-1:0]   digit_sel,
  output logic [4*NUM_DIGITS-1:0] digit_code,
  output logic [NUM_DIGITS-1:0]   digit_inv,
  output logic                    frame_valid,
  output logic                    sel_err
);

  localparam int              CW      = $clog2(STABLE_CNT + 1);
  localparam logic [CW-1:0]   CNT_MAX = CW'(STABLE_CNT);

  logic [6:0]              r_cand [NUM_DIGITS];
  logic [CW-1:0]           r_cnt  [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   r_refreshed;
  logic [4*NUM_DIGITS-1:0] r_digit_code;
  logic [NUM_DIGITS-1:0]   r_digit_inv;
  logic                    r_sel_err;

  logic [NUM_DIGITS-1:0]   w_sel;
  logic                    w_multi;
  logic                    w_onehot;
  logic [NUM_DIGITS-1:0]   w_hit;
  logic [NUM_DIGITS-1:0]   w_refresh;
  logic [CW-1:0]           w_cnt_next [NUM_DIGITS];
  seg_decode_t             w_decode;

  // One shared decoder: only the selected digit's pattern is on the bus.
  seg7_pattern_decode u_decode (
    .segments (segments),
    .decode   (w_decode)
  );

  assign w_sel    = ~digit_sel;
  assign w_multi  = |(w_sel & (w_sel - 1'b1));
  assign w_onehot = (|w_sel) & ~w_multi;

  always_comb begin
    for (int k = 0; k < NUM_DIGITS; k++) begin
      w_hit[k] = sample_en & w_onehot & w_sel[k];
      if (segments != r_cand[k])
        w_cnt_next[k] = CW'(1);
      else if (r_cnt[k] == CNT_MAX)
        w_cnt_next[k] = CNT_MAX;
      else
        w_cnt_next[k] = r_cnt[k] + CW'(1);
      w_refresh[k] = w_hit[k] && (w_cnt_next[k] == CNT_MAX);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the candidate/count arrays are plain flops, not RAM, so they are
      // reset like any other state; a stale candidate must not survive reset.
      for (int k = 0; k < NUM_DIGITS; k++) begin
        r_cand[k] <= SEG_BLANK;
        r_cnt[k]  <= '0;
      end
      r_refreshed  <= '0;
      r_digit_code <= '0;
      r_digit_inv  <= '1;
      r_sel_err    <= 1'b0;
    end else begin
      r_sel_err <= sample_en & w_multi;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (w_hit[k]) begin
          r_cand[k] <= segments;
          r_cnt[k]  <= w_cnt_next[k];
        end
        if (w_refresh[k]) begin
          r_digit_code[4*k +: 4] <= w_decode.code;
          r_digit_inv[k]         <= w_decode.inv;
        end
      end
      // A full mask is reported for one cycle, then cleared; refreshes landing
      // on the clearing edge seed the next frame.
      if (&r_refreshed)
        r_refreshed <= w_refresh;
      else
        r_refreshed <= r_refreshed | w_refresh;
    end
  end

  assign digit_code  = r_digit_code;
  assign digit_inv   = r_digit_inv;
  assign frame_valid = &r_refreshed;
  assign sel_err     = r_sel_err;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed self-checking bench for seg7_scan_decoder (NUM_DIGITS=4, STABLE_CNT=3).
// Expected values are hand-computed from the pattern table.
module tb_seg7_scan_decoder;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        sample_en = 1'b0;
  logic [6:0]  segments = 7'h7F;
  logic [3:0]  digit_sel = 4'hF;
  logic [15:0] digit_code;
  logic [3:0]  digit_inv;
  logic        frame_valid;
  logic        sel_err;

  int checks = 0;
  int errors = 0;
  int fv_count = 0;
  int se_count = 0;

  localparam logic [3:0] D0 = 4'b1110;
  localparam logic [3:0] D1 = 4'b1101;
  localparam logic [3:0] D2 = 4'b1011;
  localparam logic [3:0] D3 = 4'b0111;

  seg7_scan_decoder #(.NUM_DIGITS(4), .STABLE_CNT(3)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .sample_en   (sample_en),
    .segments    (segments),
    .digit_sel   (digit_sel),
    .digit_code  (digit_code),
    .digit_inv   (digit_inv),
    .frame_valid (frame_valid),
    .sel_err     (sel_err)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (frame_valid === 1'b1) fv_count++;
    if (sel_err === 1'b1)     se_count++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic strobe(input logic [3:0] sel, input logic [6:0] seg);
    @(negedge clock);
    sample_en = 1'b1;
    digit_sel = sel;
    segments  = seg;
    @(posedge clock);
    #1;
    sample_en = 1'b0;
    digit_sel = 4'hF;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic hold3(input logic [3:0] sel, input logic [6:0] seg);
    for (int i = 0; i < 3; i++) strobe(sel, seg);
  endtask

  task automatic table_entry(input string tag, input logic [6:0] seg,
                             input logic [3:0] code, input logic inv);
    hold3(D0, seg);
    check({tag, "_code"}, 32'(digit_code[3:0]), 32'(code));
    check({tag, "_inv"},  32'(digit_inv[0]),    32'(inv));
  endtask

  int fv_base;

  initial begin
    idle(2);
    check("rst_code", 32'(digit_code), 32'h0);
    check("rst_inv", 32'(digit_inv), 32'hF);
    check("rst_fv", 32'(frame_valid), 32'h0);
    check("rst_selerr", 32'(sel_err), 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    idle(1);

    // Debounce: accepted on the 3rd identical strobe only
    strobe(D0, 7'b1111001);
    strobe(D0, 7'b1111001);
    check("deb2_code", 32'(digit_code[3:0]), 32'h0);
    check("deb2_inv", 32'(digit_inv[0]), 32'h1);
    strobe(D0, 7'b1111001);
    check("deb3_code", 32'(digit_code[3:0]), 32'h1);
    check("deb3_inv", 32'(digit_inv[0]), 32'h0);

    // Full scan 0..3
    fv_base = fv_count;
    hold3(D0, 7'b1000000);
    hold3(D1, 7'b1111001);
    hold3(D2, 7'b0100100);
    check("scan_fv_early", 32'(frame_valid), 32'h0);
    hold3(D3, 7'b0110000);
    check("scan_fv_now", 32'(frame_valid), 32'h1);
    idle(3);
    check("scan_code", 32'(digit_code), 32'h3210);
    check("scan_inv", 32'(digit_inv), 32'h0);
    check("scan_fv_count", 32'(fv_count - fv_base), 32'd1);

    // Alternating patterns never settle
    fv_base = fv_count;
    for (int i = 0; i < 6; i++)
      strobe(D1, (i % 2 == 0) ? 7'b0100100 : 7'b0110000);
    check("alt_code", 32'(digit_code[7:4]), 32'h1);
    check("alt_fv", 32'(fv_count - fv_base), 32'd0);

    // Multi-hot select: one sel_err pulse, digit1 count (1, cand=3) preserved
    strobe(4'b1010, 7'b0110000);
    check("selerr_pulse", 32'(sel_err), 32'h1);
    idle(1);
    check("selerr_clear", 32'(sel_err), 32'h0);
    check("selerr_count", 32'(se_count), 32'd1);
    strobe(D1, 7'b0110000);
    check("selerr_cnt2", 32'(digit_code[7:4]), 32'h1);
    strobe(D1, 7'b0110000);
    check("selerr_cnt3", 32'(digit_code[7:4]), 32'h3);

    // Hex glyph on digit2
    hold3(D2, 7'b0001000);
`ifdef SEG7_DEC_HEX_EN
    check("hexA_code", 32'(digit_code[11:8]), 32'hA);
    check("hexA_inv", 32'(digit_inv[2]), 32'h0);
`else
    check("hexA_code", 32'(digit_code[11:8]), 32'hF);
    check("hexA_inv", 32'(digit_inv[2]), 32'h1);
`endif

    // Decode table on digit0
    table_entry("d4", 7'b0011001, 4'h4, 1'b0);
    table_entry("d5", 7'b0010010, 4'h5, 1'b0);
    table_entry("d6", 7'b0000010, 4'h6, 1'b0);
    table_entry("d7a", 7'b1011000, 4'h7, 1'b0);
    table_entry("d7b", 7'b1111000, 4'h7, 1'b0);
    table_entry("d8", 7'b0000000, 4'h8, 1'b0);
    table_entry("d9a", 7'b0011000, 4'h9, 1'b0);
    table_entry("d9b", 7'b0010000, 4'h9, 1'b0);
    table_entry("blank", 7'b1111111, 4'hF, 1'b1);
    table_entry("junk", 7'b1010101, 4'hF, 1'b1);
`ifdef SEG7_DEC_HEX_EN
    table_entry("hexE", 7'b0000110, 4'hE, 1'b0);
`else
    table_entry("hexE", 7'b0000110, 4'hF, 1'b1);
`endif

    // Reset mid-frame discards partial frame
    hold3(D0, 7'b0011001);
    hold3(D1, 7'b0010010);
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_code", 32'(digit_code), 32'h0);
    check("mid_rst_inv", 32'(digit_inv), 32'hF);
    idle(2);
    @(negedge clock);
    reset_n = 1'b1;
    idle(1);
    fv_base = fv_count;
    hold3(D0, 7'b0010010);
    hold3(D1, 7'b0000010);
    hold3(D2, 7'b1111000);
    check("post_rst_fv_early", 32'(frame_valid), 32'h0);
    check("post_rst_fv_none", 32'(fv_count - fv_base), 32'd0);
    hold3(D3, 7'b0000000);
    check("post_rst_fv_now", 32'(frame_valid), 32'h1);
    check("post_rst_code", 32'(digit_code), 32'h8765);
    idle(2);
    check("post_rst_fv_count", 32'(fv_count - fv_base), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
